// File: rtl/instr_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem_unit
// Description : Registered instruction memory. A fetch address is checked and
//               read every cycle, a side-band loader writes program words, and
//               a boot sequence zero-clears the whole array after reset before
//               fetches or loads are accepted.
//               Optional feature macro: IMEM_BYPASS_EN (same-cycle write to the
//               fetched address is forwarded to Instruction).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem_unit #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       IMAddress,
    output logic [DATA_W-1:0] Instruction,
    output logic              instr_valid,
    output logic              addr_err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              boot_done
);

    localparam int c_DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_count;
    logic [DATA_W-1:0]   r_mem [c_DEPTH];

    logic                w_in_range;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_wr_en;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic                w_last_clear;

    // Any set bit above the implemented address range makes the fetch illegal.
    assign w_in_range   = ((IMAddress >> ADDR_W) == 16'd0);
    assign w_rd_addr    = IMAddress[ADDR_W-1:0];
    assign w_last_clear = (r_count == {ADDR_W{1'b1}});

    // Single write port shared by the boot clear and the loader; nothing is
    // written while reset is asserted.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_count;
        w_wr_data = '0;
        if (!reset) begin
            if (r_state == ST_BOOT) begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_count;
                w_wr_data = '0;
            end else begin
                w_wr_en   = load_en;
                w_wr_addr = load_addr;
                w_wr_data = load_data;
            end
        end
    end

`ifdef IMEM_BYPASS_EN
    logic w_hit;

    // Forward the loader word when it targets the address being fetched.
    always_comb begin
        w_hit     = load_en && (load_addr == w_rd_addr);
        w_rd_data = w_hit ? load_data : r_mem[w_rd_addr];
    end
`else
    // Read-before-write: a colliding write is only seen by the next fetch.
    always_comb begin
        w_rd_data = r_mem[w_rd_addr];
    end
`endif

    // Memory array write; contents are deliberately not reset (boot clears it).
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Boot/run sequencer with registered fetch outputs and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_BOOT;
            r_count     <= '0;
            Instruction <= '0;
            instr_valid <= 1'b0;
            addr_err    <= 1'b0;
            load_ready  <= 1'b0;
            boot_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    Instruction <= '0;
                    instr_valid <= 1'b0;
                    r_count     <= r_count + 1'b1;
                    if (w_last_clear) begin
                        r_state    <= ST_RUN;
                        load_ready <= 1'b1;
                        boot_done  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    load_ready <= 1'b1;
                    boot_done  <= 1'b1;
                    if (w_in_range) begin
                        Instruction <= w_rd_data;
                        instr_valid <= 1'b1;
                    end else begin
                        Instruction <= '0;
                        instr_valid <= 1'b0;
                        addr_err    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
